// File: rtl/pulse_peak_detector.sv
// Pulse peak detector: threshold crossing, peak/width capture, pile-up tag,
// and a small event FIFO drained by a valid/ready handshake.
module pulse_peak_detector #(
    parameter int DATA_W     = 16,
    parameter int TIME_W     = 16,
    parameter int WIDTH_W    = 8,
    parameter int HOLDOFF    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] input_data,
    input  logic signed [DATA_W-1:0] threshold,
    input  logic                     event_ready,
    output logic                     event_valid,
    output logic signed [DATA_W-1:0] event_amp,
    output logic [TIME_W-1:0]        event_time,
    output logic [WIDTH_W-1:0]       event_width,
    output logic                     event_pileup,
    output logic [7:0]               lost_count
);

    typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

    localparam int HC_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int EV_W  = DATA_W + TIME_W + WIDTH_W + 1;
    localparam logic [WIDTH_W-1:0] W_MAX   = '1;
    localparam logic [HC_W-1:0]    HC_INIT = HC_W'(HOLDOFF);
    localparam logic [PTR_W:0]     FULL_N  = (PTR_W + 1)'(FIFO_DEPTH);

    state_t                     state, state_n;
    logic signed [DATA_W-1:0]   amp, amp_n;
    logic [TIME_W-1:0]          tstamp, tstamp_n;
    logic [WIDTH_W-1:0]         width, width_n;
    logic                       pileup, pileup_n;
    logic [HC_W-1:0]            hcnt, hcnt_n;
    logic [TIME_W-1:0]          time_cnt;
    logic                       above;
    logic                       push_c;
    logic                       push_q;
    logic [EV_W-1:0]            ev_q;

    logic [EV_W-1:0]            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic [PTR_W:0]             count;
    logic                       full, pop, wr_en, drop;

    assign above = input_data > threshold;

    // Pulse tracking: next state and next capture registers
    always_comb begin
        state_n  = state;
        amp_n    = amp;
        tstamp_n = tstamp;
        width_n  = width;
        pileup_n = pileup;
        hcnt_n   = hcnt;
        push_c   = 1'b0;
        unique case (state)
            IDLE: begin
                if (above) begin
                    state_n  = PULSE;
                    amp_n    = input_data;
                    tstamp_n = time_cnt;
                    width_n  = WIDTH_W'(1);
                    pileup_n = 1'b0;
                end
            end
            PULSE: begin
                if (above) begin
                    if (width != W_MAX)
                        width_n = width + WIDTH_W'(1);
                    if (input_data > amp) begin
                        amp_n    = input_data;
                        tstamp_n = time_cnt;
                    end
                end else begin
                    push_c = 1'b1;
                    if (HOLDOFF == 0) begin
                        state_n = IDLE;
                    end else begin
                        state_n = HOLD;
                        hcnt_n  = HC_INIT;
                    end
                end
            end
            HOLD: begin
                if (above) begin
                    state_n  = PULSE;
                    amp_n    = input_data;
                    tstamp_n = time_cnt;
                    width_n  = WIDTH_W'(1);
                    pileup_n = 1'b1;
                end else begin
                    hcnt_n = hcnt - HC_W'(1);
                    if (hcnt == HC_W'(1))
                        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM, capture registers, timestamp and push staging register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            amp      <= '0;
            tstamp   <= '0;
            width    <= '0;
            pileup   <= 1'b0;
            hcnt     <= '0;
            time_cnt <= '0;
            push_q   <= 1'b0;
            ev_q     <= '0;
        end else begin
            state    <= state_n;
            amp      <= amp_n;
            tstamp   <= tstamp_n;
            width    <= width_n;
            pileup   <= pileup_n;
            hcnt     <= hcnt_n;
            time_cnt <= time_cnt + TIME_W'(1);
            push_q   <= push_c;
            ev_q     <= {pileup, width, tstamp, amp};
        end
    end

    assign full  = count == FULL_N;
    assign pop   = event_valid && event_ready;
    assign wr_en = push_q && (!full || pop);
    assign drop  = push_q && full && !pop;

    // Event storage; contents are qualified by the occupancy count
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= ev_q;
    end

    // FIFO pointers, occupancy and dropped-event counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            lost_count <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_en && !pop)
                count <= count + (PTR_W + 1)'(1);
            else if (!wr_en && pop)
                count <= count - (PTR_W + 1)'(1);
            if (drop && lost_count != 8'hFF)
                lost_count <= lost_count + 8'd1;
        end
    end

    assign event_valid = count != '0;
    assign {event_pileup, event_width, event_time, event_amp} =
        event_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Directed bench for pulse_peak_detector with a queue scoreboard
// and an independent handshake monitor.
module tb_pulse_peak_detector;

    typedef struct packed {
        logic signed [15:0] amp;
        logic [15:0]        tstamp;
        logic [7:0]         width;
        logic               pileup;
    } ev_t;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic signed [15:0] input_data = '0;
    logic signed [15:0] threshold = 16'sd100;
    logic               event_ready = 1'b0;
    logic               event_valid;
    logic signed [15:0] event_amp;
    logic [15:0]        event_time;
    logic [7:0]         event_width;
    logic               event_pileup;
    logic [7:0]         lost_count;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    ev_t sb[$];
    int  vlog[$];

    pulse_peak_detector dut (
        .clk(clk),
        .reset(reset),
        .input_data(input_data),
        .threshold(threshold),
        .event_ready(event_ready),
        .event_valid(event_valid),
        .event_amp(event_amp),
        .event_time(event_time),
        .event_width(event_width),
        .event_pileup(event_pileup),
        .lost_count(lost_count)
    );

    always #5 clk = ~clk;

    // Cycle index = expected timestamp of the sample presented this cycle
    always @(posedge clk) cyc <= !reset ? 0 : cyc + 1;

    // Monitor: every accepted event is compared against the scoreboard head
    always @(negedge clk) begin
        if (reset && event_valid && event_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got amp=%0d time=%0d width=%0d pileup=%0d, expected none",
                         event_amp, event_time, event_width, event_pileup);
            end else begin
                ev_t e;
                e = sb.pop_front();
                if (event_amp !== e.amp || event_time !== e.tstamp ||
                    event_width !== e.width || event_pileup !== e.pileup) begin
                    errors++;
                    $display("FAIL event: got amp=%0d time=%0d width=%0d pileup=%0d, expected amp=%0d time=%0d width=%0d pileup=%0d",
                             event_amp, event_time, event_width, event_pileup,
                             e.amp, e.tstamp, e.width, e.pileup);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic expect_ev(input int a, input int t, input int w, input int p);
        ev_t e;
        e.amp    = 16'(a);
        e.tstamp = 16'(t);
        e.width  = 8'(w);
        e.pileup = p[0];
        sb.push_back(e);
    endtask

    task automatic drive(input int d);
        input_data = 16'(d);
        if (event_valid) vlog.push_back(cyc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_to(input int k);
        int n = 0;
        while (cyc < k && n < 20000) begin
            drive(0);
            n++;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        input_data = '0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int bad;

        // Test 1: reset values, then a quiet input for 1000 cycles
        event_ready = 1'b1;
        do_reset(5);
        check("reset_valid", int'(event_valid), 0);
        check("reset_fields", int'({event_amp, event_time, event_width, event_pileup}), 0);
        check("reset_lost", int'(lost_count), 0);
        bad = 0;
        repeat (1000) begin
            if (event_valid || lost_count != 0) bad++;
            drive(0);
        end
        check("quiet_cycles_bad", bad, 0);

        // Test 2: single pulse, peak tie keeps first stamp, e+2 latency
        do_reset(2);
        vlog.delete();
        expect_ev(300, 12, 4, 0);
        idle_to(10);
        drive(50);
        drive(150);
        drive(300);
        drive(300);
        drive(120);
        drive(80);
        idle_to(26);
        check("valid_cycle_count", vlog.size(), 1);
        if (vlog.size() == 1) check("valid_cycle", vlog[0], 17);

        // Test 3: overflow with consumer stalled, then ordered drain
        event_ready = 1'b0;
        do_reset(2);
        expect_ev(200, 10, 1, 0);
        expect_ev(300, 22, 1, 0);
        expect_ev(400, 34, 1, 0);
        expect_ev(500, 46, 1, 0);
        for (int i = 0; i < 5; i++) begin
            idle_to(10 + 12 * i);
            drive(200 + 100 * i);
        end
        idle_to(70);
        check("lost_count_full", int'(lost_count), 1);
        check("held_valid", int'(event_valid), 1);
        check("held_head_amp", int'(event_amp), 200);
        event_ready = 1'b1;
        idle_to(80);
        check("drained_valid", int'(event_valid), 0);
        check("drained_sb", sb.size(), 0);

        // Test 4: pile-up inside holdoff, clean pulse after it
        do_reset(2);
        expect_ev(250, 19, 2, 0);
        expect_ev(400, 23, 1, 1);
        expect_ev(300, 60, 1, 0);
        idle_to(18);
        drive(200);
        drive(250);
        drive(0);
        idle_to(23);
        drive(400);
        idle_to(60);
        drive(300);
        idle_to(70);
        check("pileup_sb", sb.size(), 0);

        // Test 5: long flat pulse saturates width, keeps first stamp
        do_reset(2);
        expect_ev(500, 5, 255, 0);
        idle_to(5);
        repeat (300) drive(500);
        idle_to(320);
        check("sat_sb", sb.size(), 0);

        // Test 6: reset mid-pulse discards it and restarts the timestamp
        do_reset(2);
        idle_to(10);
        drive(300);
        drive(300);
        reset = 1'b0;
        drive(300);
        drive(0);
        reset = 1'b1;
        check("restart_cyc", cyc, 0);
        expect_ev(150, 3, 1, 0);
        idle_to(3);
        drive(150);
        idle_to(15);
        check("restart_lost", int'(lost_count), 0);

        check("final_sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
